// File: rtl/hamming_decoder.sv
// Hamming(16,11) SECDED decoder: corrects single-bit errors and flags double-bit errors, behind a 2-stage valid/ready pipeline.
// Defining HAMMING_DEC_ERR_CNT_EN enables the saturating single/double error counters.
module hamming_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_message,
  output logic             out_single_err,
  output logic             out_double_err,
  output logic [3:0]       out_err_pos,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] single_err_count,
  output logic [CNT_W-1:0] double_err_count
);

  // Handshake: a word moves on valid && ready at a rising edge. Stage 2 may load
  // when it is empty or its word leaves this cycle; stage 1 may load when it is
  // empty or can hand its word to stage 2, so a full pipe drains and fills at once.
  logic w_s2_adv;
  logic w_in_fire;
  logic w_out_fire;

  logic        r_s1_valid;
  logic [15:0] r_s1_code;
  logic [3:0]  r_s1_syn;
  logic        r_s1_par;

  logic        r_s2_valid;
  logic [10:0] r_s2_msg;
  logic        r_s2_single;
  logic        r_s2_double;
  logic [3:0]  r_s2_pos;

  logic [15:0] w_flip;
  logic [15:0] w_fixed;
  logic [10:0] w_msg;
  logic        w_single;
  logic        w_double;
  logic [3:0]  w_pos;

  // S[k] is the parity of all bits whose index has bit k set.
  function automatic logic [3:0] f_syndrome(input logic [15:0] code);
    logic [3:0] syn;
    logic [3:0] idx;
    syn = '0;
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      for (int k = 0; k < 4; k++) begin
        if (idx[k]) syn[k] = syn[k] ^ code[i];
      end
    end
    return syn;
  endfunction

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_adv;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_code <= in_codeword;
        r_s1_syn  <= f_syndrome(in_codeword);
        r_s1_par  <= ^in_codeword;
      end
    end
  end

  // Odd overall parity means exactly one flipped bit; syndrome 0 then points at bit 0.
  always_comb begin
    w_flip   = r_s1_par ? (16'h0001 << r_s1_syn) : 16'h0000;
    w_fixed  = r_s1_code ^ w_flip;
    w_msg    = {w_fixed[15:9], w_fixed[7:5], w_fixed[3]};
    w_single = r_s1_par;
    w_double = !r_s1_par && (r_s1_syn != 4'd0);
    w_pos    = r_s1_par ? r_s1_syn : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_msg    <= '0;
      r_s2_single <= 1'b0;
      r_s2_double <= 1'b0;
      r_s2_pos    <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_msg    <= w_msg;
        r_s2_single <= w_single;
        r_s2_double <= w_double;
        r_s2_pos    <= w_pos;
      end
    end
  end

  assign out_valid      = r_s2_valid;
  assign out_message    = r_s2_msg;
  assign out_single_err = r_s2_single;
  assign out_double_err = r_s2_double;
  assign out_err_pos    = r_s2_pos;

`ifdef HAMMING_DEC_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_single_cnt;
  logic [CNT_W-1:0] r_double_cnt;

  // Clear wins over an increment in the same cycle; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      r_single_cnt <= '0;
      r_double_cnt <= '0;
    end else if (w_out_fire) begin
      if (r_s2_single && (r_single_cnt != CNT_MAX)) r_single_cnt <= r_single_cnt + CNT_ONE;
      if (r_s2_double && (r_double_cnt != CNT_MAX)) r_double_cnt <= r_double_cnt + CNT_ONE;
    end
  end

  assign single_err_count = r_single_cnt;
  assign double_err_count = r_double_cnt;
`else
  logic w_unused;
  assign w_unused         = cnt_clear ^ w_out_fire;
  assign single_err_count = '0;
  assign double_err_count = '0;
`endif

endmodule
